// File: rtl/mda_motor_power_sequencer.sv
// Motor power sequencer: staggers H-bridge channel enables after power-up and enforces dead time on reversals.
// Optional MOTOR_SEQ_COMB_KILL_EN: hb_out is also ANDed combinationally with power, so the kill takes effect in zero cycles.
module mda_motor_power_sequencer #(
   parameter int NUM_CH         = 8,
   parameter int STAGGER_CYCLES = 500000,
   parameter int DEADTIME       = 50
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                power,
   input  logic [4*NUM_CH-1:0] hb_in,
   output logic [4*NUM_CH-1:0] hb_out,
   output logic [NUM_CH-1:0]   ch_enabled,
   output logic                ready,
   output logic                fault
);

   localparam int CNT_W = $clog2(STAGGER_CYCLES + 1);
   localparam int IDX_W = $clog2(NUM_CH + 1);
   localparam int DT_W  = $clog2(DEADTIME + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
   localparam logic [DT_W-1:0]  DT_MAX   = DT_W'(DEADTIME);

   typedef enum logic [1:0] {ST_OFF, ST_STAGGER, ST_RUN} state_t;
   typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_REV, DIR_ILLEGAL} dir_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*NUM_CH-1:0] hb_q;
   logic [4*NUM_CH-1:0] hb_nxt;
   logic                fault_nxt;
   dir_t                req;
   dir_t                last_dir [NUM_CH];
   dir_t                dir_nxt  [NUM_CH];
   logic [DT_W-1:0]     dt_cnt   [NUM_CH];

   function automatic dir_t decode(input logic [3:0] nib);
      dir_t d;
      if (nib == 4'd0)             d = DIR_NONE;
      else if (nib[1:0] == 2'd0)   d = DIR_FWD;
      else if (nib[3:2] == 2'd0)   d = DIR_REV;
      else                         d = DIR_ILLEGAL;
      return d;
   endfunction

   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
      hb_nxt    = '0;
      fault_nxt = 1'b0;
      req       = DIR_NONE;
      for (int k = 0; k < NUM_CH; k++) begin
         dir_nxt[k] = last_dir[k];
         req        = decode(hb_in[4*k +: 4]);
         if (power && ch_enabled[k]) begin
            if (req == DIR_ILLEGAL) begin
               fault_nxt = 1'b1;
            end else if (req != DIR_NONE &&
                         (req == last_dir[k] || last_dir[k] == DIR_NONE || dt_cnt[k] >= DT_MAX)) begin
               hb_nxt[4*k +: 4] = hb_in[4*k +: 4];
               dir_nxt[k]       = req;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_OFF;
         cnt        <= '0;
         idx        <= '0;
         ch_enabled <= '0;
         ready      <= 1'b0;
         fault      <= 1'b0;
         hb_q       <= '0;
         // NOTE: the per-channel arrays are tiny flops, not RAM, so they take the reset like any register.
         for (int k = 0; k < NUM_CH; k++) begin
            last_dir[k] <= DIR_NONE;
            dt_cnt[k]   <= DT_MAX;
         end
      end else begin
         hb_q  <= hb_nxt;
         fault <= fault_nxt;

         // dt_cnt counts consecutive all-off output cycles; OFF forgets history so a restart has no penalty.
         for (int k = 0; k < NUM_CH; k++) begin
            if (state == ST_OFF) begin
               last_dir[k] <= DIR_NONE;
               dt_cnt[k]   <= DT_MAX;
            end else begin
               last_dir[k] <= dir_nxt[k];
               if (hb_nxt[4*k +: 4] != 4'd0) dt_cnt[k] <= '0;
               else if (dt_cnt[k] != DT_MAX) dt_cnt[k] <= dt_cnt[k] + DT_W'(1);
            end
         end

         if (!power) begin
            state      <= ST_OFF;
            cnt        <= '0;
            idx        <= '0;
            ch_enabled <= '0;
            ready      <= 1'b0;
         end else begin
            case (state)
               ST_OFF: state <= ST_STAGGER;
               ST_STAGGER: begin
                  if (cnt == CNT_LAST) begin
                     cnt <= '0;
                     idx <= idx + IDX_W'(1);
                     for (int k = 0; k < NUM_CH; k++) begin
                        if (IDX_W'(k) == idx) ch_enabled[k] <= 1'b1;
                     end
                     if (idx == IDX_LAST) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               ST_RUN: state <= ST_RUN;
               default: state <= ST_OFF;
            endcase
         end
      end
   end

`ifdef MOTOR_SEQ_COMB_KILL_EN
   assign hb_out = hb_q & {(4*NUM_CH){power}};
`else
   assign hb_out = hb_q;
`endif

endmodule

// File: tb/tb_mda_motor_power_sequencer.sv
// Self-checking bench for mda_motor_power_sequencer: directed scenarios plus randomized traffic
// against a cycle-count based reference model (NUM_CH=2, STAGGER_CYCLES=4, DEADTIME=3).
module tb_mda_motor_power_sequencer;

   localparam int NUM_CH = 2;
   localparam int STG    = 4;
   localparam int DT     = 3;
   localparam int BIG    = 1000000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       power = 1'b0;
   logic [7:0] hb_in = 8'h00;
   logic [7:0] hb_out;
   logic [1:0] ch_enabled;
   logic       ready;
   logic       fault;

   always #5 clk = ~clk;

   mda_motor_power_sequencer #(
      .NUM_CH(NUM_CH), .STAGGER_CYCLES(STG), .DEADTIME(DT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .power(power), .hb_in(hb_in),
      .hb_out(hb_out), .ch_enabled(ch_enabled), .ready(ready), .fault(fault)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: enables follow from how many consecutive powered edges have elapsed,
   // dead time from how many consecutive all-off output cycles each channel has seen.
   int         run_len;
   int         idle [NUM_CH];
   int         last [NUM_CH];   // 0 none, 1 fwd, 2 rev
   logic [7:0] exp_hb;
   logic [1:0] exp_en;
   logic       exp_ready;
   logic       exp_fault;

   function automatic int classify(input logic [3:0] n);
      if (n == 4'd0) return 0;
      if (n[3:2] != 2'd0 && n[1:0] != 2'd0) return 3;
      if (n[3:2] != 2'd0) return 1;
      return 2;
   endfunction

   task automatic model_reset();
      run_len = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         idle[k] = BIG;
         last[k] = 0;
      end
      exp_hb = 8'h00; exp_en = 2'b00; exp_ready = 1'b0; exp_fault = 1'b0;
   endtask

   task automatic model_step();
      logic [7:0] new_hb;
      logic       new_fault;
      logic [3:0] nib;
      int         d;
      bit         was_off;
      was_off   = (run_len == 0);
      new_hb    = 8'h00;
      new_fault = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         nib = hb_in[4*k +: 4];
         d   = classify(nib);
         if (power && exp_en[k]) begin
            if (d == 3) new_fault = 1'b1;
            else if (d != 0 && (last[k] == 0 || last[k] == d || idle[k] >= DT)) begin
               new_hb[4*k +: 4] = nib;
               last[k] = d;
            end
         end
         if (new_hb[4*k +: 4] != 4'd0) idle[k] = 0;
         else if (idle[k] < BIG) idle[k]++;
         if (was_off) begin
            idle[k] = BIG;
            last[k] = 0;
         end
      end
      run_len = power ? ((run_len < BIG) ? run_len + 1 : run_len) : 0;
      for (int k = 0; k < NUM_CH; k++) exp_en[k] = (run_len >= 1 + STG*(k+1));
      exp_ready = (run_len >= 1 + STG*NUM_CH);
      exp_hb    = new_hb;
      exp_fault = new_fault;
   endtask

   task automatic compare_all(input string tag);
      logic [7:0] e;
`ifdef MOTOR_SEQ_COMB_KILL_EN
      e = exp_hb & {8{power}};
`else
      e = exp_hb;
`endif
      check({tag, ".hb_out"}, hb_out, e);
      check({tag, ".ch_enabled"}, ch_enabled, exp_en);
      check({tag, ".ready"}, ready, exp_ready);
      check({tag, ".fault"}, fault, exp_fault);
   endtask

   // Drive at the falling edge, let the model take the rising edge, compare at the next falling edge.
   task automatic cycle(input logic p, input logic [7:0] h, input string tag);
      power = p;
      hb_in = h;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all(tag);
   endtask

   function automatic logic [3:0] make_nib(input int kind);
      logic [1:0] a, b;
      a = 2'($urandom_range(1, 3));
      b = 2'($urandom_range(1, 3));
      case (kind)
         0: return 4'd0;
         1: return {a, 2'b00};
         2: return {2'b00, a};
         default: return {a, b};
      endcase
   endfunction

   logic [7:0] t2_stim [8] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h00, 8'h0C, 8'h0C, 8'h0C};
   logic [3:0] t2_exp  [8] = '{4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'hC};

   initial begin
      logic [7:0] h;
      int         r;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all("reset");
      reset_n = 1'b1;

      // Power-up stagger
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b1, 8'hCC, "t1");
         if (i == 4) check("t1.en_before_ch0", ch_enabled, 2'b00);
         if (i == 5) check("t1.en_ch0", ch_enabled, 2'b01);
         if (i == 6) check("t1.hb_ch0", hb_out, 8'h0C);
         if (i == 8) check("t1.ready_early", ready, 1'b0);
         if (i == 9) begin
            check("t1.en_all", ch_enabled, 2'b11);
            check("t1.ready", ready, 1'b1);
         end
         if (i == 10) check("t1.hb_all", hb_out, 8'hCC);
      end

      // Reversal with dead time, then a short idle gap that still blocks the reversal
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, t2_stim[i], "t2");
         check($sformatf("t2.ch0_step%0d", i), hb_out[3:0], t2_exp[i]);
      end

      // Shoot-through request on ch1
      cycle(1'b1, 8'hFC, "t3");
      check("t3.ch1_blocked", hb_out[7:4], 4'h0);
      check("t3.fault", fault, 1'b1);
      check("t3.ch0_pass", hb_out[3:0], 4'hC);
      cycle(1'b1, 8'h0C, "t3b");
      check("t3.fault_clear", fault, 1'b0);

      // Mid-stagger power drop restarts the full sequence
      cycle(1'b0, 8'h00, "t4off");
      for (int i = 1; i <= 6; i++) cycle(1'b1, 8'hCC, "t4a");
      check("t4.partial_en", ch_enabled, 2'b01);
      cycle(1'b0, 8'hCC, "t4drop");
      check("t4.drop_hb", hb_out, 8'h00);
      check("t4.drop_en", ch_enabled, 2'b00);
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b1, 8'hCC, "t4b");
         if (i == 4) check("t4.no_resume", ch_enabled, 2'b00);
         if (i == 5) check("t4.reenable", ch_enabled, 2'b01);
      end

      // Asynchronous reset in RUN
      #2 reset_n = 1'b0;
      #1;
      check("t5.hb_async", hb_out, 8'h00);
      check("t5.ready_async", ready, 1'b0);
      check("t5.en_async", ch_enabled, 2'b00);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 1; i <= 5; i++) cycle(1'b1, 8'hCC, "t5post");
      check("t5.restart_en", ch_enabled, 2'b01);

`ifdef MOTOR_SEQ_COMB_KILL_EN
      for (int i = 1; i <= 6; i++) cycle(1'b1, 8'hCC, "t6run");
      power = 1'b0;
      #1;
      check("t6.comb_kill", hb_out, 8'h00);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all("t6after");
`endif

      // Randomized traffic
      h = 8'hCC;
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if ($urandom_range(0, 2) == 0) begin
               r = $urandom_range(0, 9);
               h[4*k +: 4] = make_nib((r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3);
            end
         end
         cycle(($urandom_range(0, 59) != 0), h, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
